// File: rtl/dense_layer_mac_ctrl_pkg.sv
// Shared defaults, MNIST layer sizes and sequencer state encoding for the dense-layer MAC controller.
package dense_layer_mac_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 12;
  localparam int DEF_ACC_WIDTH  = 64;

  localparam int IMG_PIXELS  = 784;
  localparam int L1_IN_SIZE  = 196;
  localparam int L1_OUT_SIZE = 60;
  localparam int L2_OUT_SIZE = 30;
  localparam int L3_OUT_SIZE = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/dense_layer_mac_ctrl_if.sv
// Control handshake plus input/weight/output BRAM ports of one dense layer; master = sequencer side.
interface dense_layer_mac_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_AW      = 9,
  parameter int W_AW       = 14,
  parameter int OUT_AW     = 9
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         in_ce;
  logic [IN_AW-1:0]             in_addr;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic                         w_ce;
  logic [W_AW-1:0]              w_addr;
  logic signed [DATA_WIDTH-1:0] w_q;
  logic                         out_we;
  logic [OUT_AW-1:0]            out_addr;
  logic [DATA_WIDTH-1:0]        out_data;

  modport master (
    input  start, in_q, w_q,
    output busy, done, in_ce, in_addr, w_ce, w_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, in_q, w_q,
    input  busy, done, in_ce, in_addr, w_ce, w_addr, out_we, out_addr, out_data
  );
endinterface

// File: rtl/dense_layer_mac_ctrl_mac_unit.sv
// Two-stage signed multiply-accumulate: registered product, then sign-extended accumulate; clr has priority.
module dense_layer_mac_ctrl_mac_unit
  import dense_layer_mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         vld,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                           prod_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= vld;
      if (vld) begin
        prod <= a * b;
      end
      if (clr) begin
        acc <= '0;
      end else if (prod_vld) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

endmodule

// File: rtl/dense_layer_mac_ctrl.sv
// Dense-layer sequencer: streams IN_SIZE activation/weight pairs per neuron, writes sat(acc>>>FRAC_BITS).
// Define DENSE_RELU_EN to clamp negative results to zero (hidden layers).
module dense_layer_mac_ctrl
  import dense_layer_mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int IN_SIZE    = L1_IN_SIZE,
  parameter int OUT_SIZE   = L1_OUT_SIZE,
  parameter int IN_AW      = 9,
  parameter int W_AW       = 14,
  parameter int OUT_AW     = 9
) (
  input logic                    clk,
  input logic                    reset,
  dense_layer_mac_ctrl_if.master bus
);

  localparam logic [IN_AW-1:0]  LAST_IN     = IN_AW'(IN_SIZE - 1);
  localparam logic [OUT_AW-1:0] LAST_NEURON = OUT_AW'(OUT_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                        state;
  logic [1:0]                    drain_cnt;
  logic [OUT_AW-1:0]             neuron;
  logic                          q_vld;
  logic                          mac_clr;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic signed [DATA_WIDTH-1:0]  sat_val;
  logic signed [DATA_WIDTH-1:0]  result;

  // BRAM data lags the clock enable by one cycle; this flag tags in_q/w_q as a live pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_vld <= 1'b0;
    end else begin
      q_vld <= bus.in_ce;
    end
  end

  assign mac_clr = (state == IDLE) || (state == WRITE) || (state == DONE);

  dense_layer_mac_ctrl_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .vld  (q_vld),
    .a    (bus.in_q),
    .b    (bus.w_q),
    .acc  (acc)
  );

  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_val = shifted[DATA_WIDTH-1:0];
    end
`ifdef DENSE_RELU_EN
    result = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.in_ce    <= 1'b0;
      bus.w_ce     <= 1'b0;
      bus.out_we   <= 1'b0;
      bus.in_addr  <= '0;
      bus.w_addr   <= '0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      neuron       <= '0;
      drain_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= ISSUE;
            bus.busy    <= 1'b1;
            bus.in_ce   <= 1'b1;
            bus.w_ce    <= 1'b1;
            bus.in_addr <= '0;
            bus.w_addr  <= '0;
            neuron      <= '0;
          end
        end
        ISSUE: begin
          // w_addr runs across neurons, so the row-major offset never needs a multiply.
          bus.w_addr <= bus.w_addr + W_AW'(1);
          if (bus.in_addr == LAST_IN) begin
            state       <= DRAIN;
            bus.in_ce   <= 1'b0;
            bus.w_ce    <= 1'b0;
            bus.in_addr <= '0;
            drain_cnt   <= '0;
          end else begin
            bus.in_addr <= bus.in_addr + IN_AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state        <= WRITE;
            bus.out_we   <= 1'b1;
            bus.out_addr <= neuron;
            bus.out_data <= result;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        WRITE: begin
          bus.out_we <= 1'b0;
          if (neuron == LAST_NEURON) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            neuron    <= neuron + OUT_AW'(1);
            state     <= ISSUE;
            bus.in_ce <= 1'b1;
            bus.w_ce  <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
